// File: rtl/borrow_skip_sub16.sv
// Sequential 16-bit subtractor: one 4-bit borrow-skip nibble per cycle.
// Ports: clk, rst (sync, high), in_valid/in_ready + A, B, Bin in;
//   out_valid/out_ready + Diff, Bout out; Zero, Ovf under SUB_FLAGS_EN.
module borrow_skip_sub16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Diff,
  output logic        Bout
`ifdef SUB_FLAGS_EN
  ,
  output logic        Zero,
  output logic        Ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [1:0]  cnt_q;
  logic        bw_q;

  logic [3:0]  na;
  logic [3:0]  nb;
  logic [3:0]  nd;
  logic        rip_bout;
  logic        skip;
  logic        nib_bout;
  logic        bw;
  logic        last;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign last      = (cnt_q == 2'd3);

  // Ripple-borrow nibble; when every bit pair
  // matches the borrow just passes through.
  always_comb begin
    na       = a_q[{cnt_q, 2'b00} +: 4];
    nb       = b_q[{cnt_q, 2'b00} +: 4];
    nd       = 4'h0;
    bw       = bw_q;
    for (int i = 0; i < 4; i++) begin
      nd[i] = na[i] ^ nb[i] ^ bw;
      bw    = (~na[i] & nb[i])
            | (~(na[i] ^ nb[i]) & bw);
    end
    rip_bout = bw;
    skip     = &(~(na ^ nb));
    nib_bout = skip ? bw_q : rip_bout;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CALC;
      CALC: if (last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= 16'h0;
      b_q   <= 16'h0;
      cnt_q <= 2'd0;
      bw_q  <= 1'b0;
      Diff  <= 16'h0;
      Bout  <= 1'b0;
`ifdef SUB_FLAGS_EN
      Zero  <= 1'b0;
      Ovf   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            cnt_q <= 2'd0;
            bw_q  <= Bin;
          end
        end
        CALC: begin
          Diff[{cnt_q, 2'b00} +: 4] <= nd;
          bw_q  <= nib_bout;
          cnt_q <= cnt_q + 2'd1;
          if (last) begin
            Bout <= nib_bout;
`ifdef SUB_FLAGS_EN
            // Top nibble is not yet in Diff here.
            Zero <= ({nd, Diff[11:0]} == 16'h0);
            Ovf  <= (a_q[15] != b_q[15])
                  & (nd[3] != a_q[15]);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_skip_sub16.sv
// Bench for borrow_skip_sub16: directed table,
// backpressure, mid-op reset and random ops.
module tb_borrow_skip_sub16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
`ifdef SUB_FLAGS_EN
  logic        Zero;
  logic        Ovf;
`endif

  int checks = 0;
  int errors = 0;

  borrow_skip_sub16 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .B        (B),
    .Bin      (Bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Diff     (Diff),
    .Bout     (Bout)
`ifdef SUB_FLAGS_EN
    ,
    .Zero     (Zero),
    .Ovf      (Ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } vec_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic scramble(input bit noise);
    A   = 16'($urandom);
    B   = 16'($urandom);
    Bin = 1'($urandom);
    in_valid = noise ? 1'($urandom) : 1'b0;
  endtask

  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input logic bin,
                        input int hold,
                        input bit noise,
                        output logic [15:0] d,
                        output logic bo,
                        output logic z,
                        output logic ov);
    int lat;
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    A = a; B = b; Bin = bin;
    in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    scramble(noise);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
      scramble(noise);
    end
    check("latency", lat, 4);
    d  = Diff;
    bo = Bout;
`ifdef SUB_FLAGS_EN
    z  = Zero;
    ov = Ovf;
`else
    z  = 1'b0;
    ov = 1'b0;
`endif
    for (int i = 0; i < hold; i++) begin
      scramble(noise);
      @(negedge clk);
      check("hold",
            {13'd0, out_valid, in_ready, Bout, Diff},
            {13'd0, 1'b1, 1'b0, bo, d});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release", {30'd0, out_valid, in_ready},
          32'd1);
  endtask

  vec_t        tbl[10];
  logic [15:0] d;
  logic        bo;
  logic        z;
  logic        ov;
  logic [16:0] ref_r;

  initial begin
    tbl[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h5555, 16'h5555, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
    tbl[8] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[9] = '{16'h1000, 16'h0FFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0; B = 16'h0; Bin = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",
          {13'd0, in_ready, out_valid, Bout, Diff},
          {13'd0, 1'b1, 1'b0, 1'b0, 16'h0});
`ifdef SUB_FLAGS_EN
    check("reset_flags", {30'd0, Zero, Ovf}, 32'd0);
`endif
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, 1, 1'b0,
             d, bo, z, ov);
      check($sformatf("vec%0d_diff", i), {16'd0, d},
            {16'd0, tbl[i].diff});
      check($sformatf("vec%0d_bout", i), {31'd0, bo},
            {31'd0, tbl[i].bout});
`ifdef SUB_FLAGS_EN
      check($sformatf("vec%0d_flags", i), {30'd0, z, ov},
            {30'd0, tbl[i].zero, tbl[i].ovf});
`endif
    end

    // Backpressure with noisy inputs throughout.
    run_op(16'hC0DE, 16'h1234, 1'b0, 10, 1'b1,
           d, bo, z, ov);
    check("bp_diff", {15'd0, bo, d}, {15'd0, 1'b0, 16'hAEAA});
    repeat (3) begin
      @(negedge clk);
      check("bp_single", {31'd0, out_valid}, 32'd0);
    end

    // Reset at cnt = 2 after two nibbles written.
    @(negedge clk);
    A = 16'h1234; B = 16'h0111; Bin = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid",
          {14'd0, out_valid, in_ready, Diff},
          {14'd0, 1'b0, 1'b1, 16'h0});
    repeat (6) begin
      @(negedge clk);
      check("rst_no_out", {31'd0, out_valid}, 32'd0);
    end
    run_op(16'h0010, 16'h0001, 1'b0, 0, 1'b0,
           d, bo, z, ov);
    check("post_rst", {15'd0, bo, d}, {15'd0, 1'b0, 16'h000F});

    for (int n = 0; n < 10000; n++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rbin;
      int          h;
      ra   = 16'($urandom);
      rb   = 16'($urandom);
      rbin = 1'($urandom);
      h    = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ref_r = {1'b0, ra} - {1'b0, rb} - {16'd0, rbin};
      run_op(ra, rb, rbin, h, 1'b0, d, bo, z, ov);
      check("rand", {15'd0, bo, d},
            {15'd0, ref_r[16], ref_r[15:0]});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/borrow_skip_sub16.md
BORROW_SKIP_SUB16 -- requirements
Module: borrow_skip_sub16

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_valid, input, 1 bit: operands and borrow-in are valid.
REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-005 SHALL have port A, input, 16 bits: minuend.
REQ-006 SHALL have port B, input, 16 bits: subtrahend.
REQ-007 SHALL have port Bin, input, 1 bit: borrow-in.
REQ-008 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port Diff, output, 16 bits: A - B - Bin, modulo 2^16.
REQ-011 SHALL have port Bout, output, 1 bit: borrow-out, 1 when A < B + Bin unsigned.
REQ-012 SHALL have ports Zero and Ovf, outputs, 1 bit each, present only under SUB_FLAGS_EN (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 SHALL drive in_ready = 1 only in IDLE; an accept is in_valid & in_ready on a rising edge.
REQ-015 SHALL, on accept, register A, B and Bin, clear nibble counter cnt to 0, load the borrow register with Bin, and enter CALC.
REQ-016 SHALL process one 4-bit nibble per CALC cycle, LSB nibble first (cnt 0..3); nibble i = bits [4i+3:4i].
REQ-017 SHALL compute each nibble with a 4-bit ripple-borrow stage: d = a ^ b ^ bw, bw_next = (~a & b) | (~(a ^ b) & bw).
REQ-018 SHALL apply borrow-skip per nibble: if every bit of the nibble has a == b, the nibble borrow-out equals the nibble borrow-in; otherwise it equals the ripple-stage borrow-out; the two results are logically identical.
REQ-019 SHALL write the nibble result into Diff[4i+3:4i] and update the borrow register every CALC cycle.
REQ-020 SHALL leave CALC for DONE after cnt = 3, setting out_valid = 1 and Bout = final borrow; latency is exactly 4 clocks from accept to out_valid = 1.
REQ-021 SHALL hold Diff, Bout, flags and out_valid stable in DONE while out_ready = 0 (backpressure, unlimited duration).
REQ-022 SHALL, on out_valid & out_ready, return to IDLE with out_valid = 0 on the next cycle; no new accept occurs in that same cycle (throughput one operation per 6 clocks minimum).
REQ-023 SHALL ignore in_valid in CALC and DONE, and SHALL ignore A, B and Bin changes after accept.
REQ-024 SHALL hold Diff at its last value in IDLE; Diff is defined only while out_valid = 1.

Reset
REQ-025 SHALL, when rst = 1 at a rising edge, enter IDLE and set in_ready = 1, out_valid = 0, Diff = 0x0000, Bout = 0, cnt = 0, borrow register = 0, Zero = 0 and Ovf = 0.
REQ-026 SHALL let rst take priority over accept and handshake in every state; reset mid-CALC or mid-DONE discards the operation with no result output.

Configuration
REQ-027 SHALL, with macro SUB_FLAGS_EN defined, provide Zero = (Diff == 0) and Ovf = (A[15] != B[15]) & (Diff[15] != A[15]) (two's-complement overflow), both valid with out_valid and held with Diff.
REQ-028 SHALL, without SUB_FLAGS_EN, omit the Zero and Ovf ports and their logic; all other behaviour is unchanged.

Verification
REQ-029 SHALL pass test 1: A = 0x1234, B = 0x0234, Bin = 0 -> out_valid 4 clocks after accept, Diff = 0x1000, Bout = 0, Zero = 0, Ovf = 0.
REQ-030 SHALL pass test 2: A = 0x0000, B = 0x0001, Bin = 0 -> Diff = 0xFFFF, Bout = 1; and A = 0x5555, B = 0x5555, Bin = 1 (all nibbles skip) -> Diff = 0xFFFF, Bout = 1.
REQ-031 SHALL pass test 3: A = 0x8000, B = 0x0001, Bin = 0 -> Diff = 0x7FFF, Bout = 0, Ovf = 1; and A = 0xABCD, B = 0xABCD, Bin = 0 -> Diff = 0x0000, Zero = 1.
REQ-032 SHALL pass test 4: hold out_ready = 0 for 10 clocks after out_valid while toggling in_valid, A and B -> Diff and Bout stable, in_ready = 0 throughout, one result delivered.
REQ-033 SHALL pass test 5: assert rst during cnt = 2 -> the next cycle is IDLE with out_valid = 0, Diff = 0x0000 and in_ready = 1, and a following operation 0x0010 - 0x0001 returns 0x000F.
REQ-034 SHALL pass test 6: 10,000 random A/B/Bin operations with random out_ready -> every Diff and Bout matches the reference model A - B - Bin.
